// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: major opcodes, issue op classes and immediate formats.
package rv32i_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpimm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [OPW-1:0] {
        OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
        OpStore, OpOpimm, OpOp, OpFence, OpSystem, OpIllegal
    } op_e;

    typedef enum logic [2:0] {
        ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ
    } imm_fmt_e;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decode: op class, regfile read enables, destination use, immediate.
module rv32i_decoder
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output op_e             op,
    output logic            re1,
    output logic            re2,
    output logic            uses_rd,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    fmt;
    logic        writes_rd;
    logic [31:0] imm32;

    always_comb begin
        op        = OpIllegal;
        fmt       = ImmNone;
        re1       = 1'b0;
        re2       = 1'b0;
        writes_rd = 1'b0;
        // Every legal opcode ends in 2'b11, so compressed/garbage words fall to the default.
        case (instr[6:0])
            OpcLui:    begin op = OpLui;    fmt = ImmU; writes_rd = 1'b1; end
            OpcAuipc:  begin op = OpAuipc;  fmt = ImmU; writes_rd = 1'b1; end
            OpcJal:    begin op = OpJal;    fmt = ImmJ; writes_rd = 1'b1; end
            OpcJalr:   begin op = OpJalr;   fmt = ImmI; writes_rd = 1'b1; re1 = 1'b1; end
            OpcBranch: begin op = OpBranch; fmt = ImmB; re1 = 1'b1; re2 = 1'b1; end
            OpcLoad:   begin op = OpLoad;   fmt = ImmI; writes_rd = 1'b1; re1 = 1'b1; end
            OpcStore:  begin op = OpStore;  fmt = ImmS; re1 = 1'b1; re2 = 1'b1; end
            OpcOpimm:  begin op = OpOpimm;  fmt = ImmI; writes_rd = 1'b1; re1 = 1'b1; end
            OpcOp:     begin op = OpOp;     writes_rd = 1'b1; re1 = 1'b1; re2 = 1'b1; end
            OpcFence:  op = OpFence;
            OpcSystem: op = OpSystem;
            default:   op = OpIllegal;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            ImmI: imm32 = {{20{instr[31]}}, instr[31:20]};
            ImmS: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU: imm32 = {instr[31:12], 12'b0};
            ImmJ: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                           1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm     = XLEN'($signed(imm32));
    assign uses_rd = writes_rd && (instr[11:7] != 5'd0);

endmodule

// File: rtl/id_issue.sv
// RV32I decode/issue stage: busy-bit scoreboard for RAW/WAW stalls and one registered issue slot.
module id_issue
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned OPW  = rv32i_pkg::OPW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            re1,
    output logic            re2,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OPW-1:0]  ex_op,
    output logic [2:0]      ex_funct3,
    output logic            ex_f7b5,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1v,
    output logic [XLEN-1:0] ex_rs2v,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we
);

    op_e             dec_op;
    logic            dec_uses_rd;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      rd;
    logic            hazard;
    logic            accept;
    logic [NREG-1:0] busy_q, busy_d;

    rv32i_decoder #(
        .XLEN (XLEN)
    ) u_decoder (
        .instr   (if_instr),
        .op      (dec_op),
        .re1     (re1),
        .re2     (re2),
        .uses_rd (dec_uses_rd),
        .imm     (dec_imm)
    );

    assign ra1 = if_instr[19:15];
    assign ra2 = if_instr[24:20];
    assign rd  = if_instr[11:7];

    assign hazard = (re1 && (ra1 != 5'd0) && busy_q[ra1]) ||
                    (re2 && (ra2 != 5'd0) && busy_q[ra2]) ||
                    (dec_uses_rd && busy_q[rd]);

    assign if_ready = !reset && !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // Clears first, then the set, so a same-index set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_rd != 5'd0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        // A flushed slot never reaches writeback, so its claim must be dropped here.
        if (flush && ex_valid && ex_rd_we) begin
            busy_d[ex_rd] = 1'b0;
        end
        if (accept && dec_uses_rd) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_op     <= '0;
            ex_funct3 <= '0;
            ex_f7b5   <= 1'b0;
            ex_pc     <= '0;
            ex_rs1v   <= '0;
            ex_rs2v   <= '0;
            ex_imm    <= '0;
            ex_rd     <= '0;
            ex_rd_we  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            ex_op     <= OPW'(dec_op);
            ex_funct3 <= if_instr[14:12];
            ex_f7b5   <= if_instr[30];
            ex_pc     <= if_pc;
            ex_rs1v   <= rs1_data;
            ex_rs2v   <= rs2_data;
            ex_imm    <= dec_imm;
            ex_rd     <= rd;
            ex_rd_we  <= dec_uses_rd;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed scenarios plus random traffic against a reference model.
module tb_id_issue;
    import rv32i_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        re1, re2;
    logic [4:0]  ra1, ra2;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic        ex_f7b5;
    logic [31:0] ex_pc, ex_rs1v, ex_rs2v, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    id_issue #(
        .XLEN (32),
        .NREG (32),
        .OPW  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .re1       (re1),
        .re2       (re2),
        .ra1       (ra1),
        .ra2       (ra2),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_funct3 (ex_funct3),
        .ex_f7b5   (ex_f7b5),
        .ex_pc     (ex_pc),
        .ex_rs1v   (ex_rs1v),
        .ex_rs2v   (ex_rs2v),
        .ex_imm    (ex_imm),
        .ex_rd     (ex_rd),
        .ex_rd_we  (ex_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        op_e         op;
        bit          re1;
        bit          re2;
        bit          uses_rd;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        bit          valid;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          we;
    } slot_t;

    bit [31:0] m_busy;
    slot_t     m_slot;

    // Interpret an n-bit two's-complement field as a signed number, return it as 32 bits.
    function automatic logic [31:0] sx(input longint field, input int bits);
        longint v;
        v = field;
        if (((field >> (bits - 1)) & 1) == 1) v = field - (longint'(1) << bits);
        return 32'(v);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t   d;
        longint fi, fs, fb, fj;
        fi = longint'(w[31:20]);
        fs = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        fb = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
           + longint'(w[11:8]) * 2;
        fj = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
           + longint'(w[30:21]) * 2;
        d.op = OpIllegal; d.re1 = 0; d.re2 = 0; d.uses_rd = 0; d.imm = 32'd0;
        case (w[6:0])
            7'h37: begin d.op = OpLui;    d.uses_rd = 1; d.imm = {w[31:12], 12'd0}; end
            7'h17: begin d.op = OpAuipc;  d.uses_rd = 1; d.imm = {w[31:12], 12'd0}; end
            7'h6F: begin d.op = OpJal;    d.uses_rd = 1; d.imm = sx(fj, 21); end
            7'h67: begin d.op = OpJalr;   d.uses_rd = 1; d.re1 = 1; d.imm = sx(fi, 12); end
            7'h63: begin d.op = OpBranch; d.re1 = 1; d.re2 = 1; d.imm = sx(fb, 13); end
            7'h03: begin d.op = OpLoad;   d.uses_rd = 1; d.re1 = 1; d.imm = sx(fi, 12); end
            7'h23: begin d.op = OpStore;  d.re1 = 1; d.re2 = 1; d.imm = sx(fs, 12); end
            7'h13: begin d.op = OpOpimm;  d.uses_rd = 1; d.re1 = 1; d.imm = sx(fi, 12); end
            7'h33: begin d.op = OpOp;     d.uses_rd = 1; d.re1 = 1; d.re2 = 1; end
            7'h0F: d.op = OpFence;
            7'h73: d.op = OpSystem;
            default: d.op = OpIllegal;
        endcase
        if (w[11:7] == 5'd0) d.uses_rd = 0;
        return d;
    endfunction

    task automatic step(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                        input logic [31:0] pc, input bit wbv, input logic [4:0] wbr,
                        input bit exr);
        dec_t        d;
        bit          hz, rdy, acc;
        logic [31:0] r1, r2;
        r1 = $urandom;
        r2 = $urandom;
        reset = rst; flush = fl; if_valid = iv; if_instr = ins; if_pc = pc;
        wb_valid = wbv; wb_rd = wbr; ex_ready = exr; rs1_data = r1; rs2_data = r2;
        #1;
        d  = ref_decode(ins);
        hz = (d.re1 && ins[19:15] != 0 && m_busy[ins[19:15]] == 1'b1)
          || (d.re2 && ins[24:20] != 0 && m_busy[ins[24:20]] == 1'b1)
          || (d.uses_rd && m_busy[ins[11:7]] == 1'b1);
        rdy = !rst && !fl && !hz && (!m_slot.valid || exr);
        check_eq("if_ready", 64'(if_ready), 64'(rdy));
        check_eq("re1", 64'(re1), 64'(d.re1));
        check_eq("re2", 64'(re2), 64'(d.re2));
        check_eq("ra1", 64'(ra1), 64'(ins[19:15]));
        check_eq("ra2", 64'(ra2), 64'(ins[24:20]));

        acc = iv && rdy;
        if (rst) begin
            m_busy = '0;
            m_slot = '{valid: 0, op: 0, f3: 0, f7b5: 0, pc: 0, rs1v: 0, rs2v: 0, imm: 0,
                       rd: 0, we: 0};
        end else begin
            if (wbv) m_busy[wbr] = 1'b0;
            if (fl && m_slot.valid && m_slot.we) m_busy[m_slot.rd] = 1'b0;
            if (acc && d.uses_rd) m_busy[ins[11:7]] = 1'b1;
            m_busy[0] = 1'b0;
            if (fl) m_slot.valid = 0;
            else if (acc) begin
                m_slot.valid = 1;
                m_slot.op    = 4'(d.op);
                m_slot.f3    = ins[14:12];
                m_slot.f7b5  = ins[30];
                m_slot.pc    = pc;
                m_slot.rs1v  = r1;
                m_slot.rs2v  = r2;
                m_slot.imm   = d.imm;
                m_slot.rd    = ins[11:7];
                m_slot.we    = d.uses_rd;
            end else if (exr) m_slot.valid = 0;
        end

        @(posedge clk);
        #1;
        check_eq("ex_valid", 64'(ex_valid), 64'(m_slot.valid));
        if (m_slot.valid || rst) begin
            check_eq("ex_op", 64'(ex_op), 64'(m_slot.op));
            check_eq("ex_funct3", 64'(ex_funct3), 64'(m_slot.f3));
            check_eq("ex_f7b5", 64'(ex_f7b5), 64'(m_slot.f7b5));
            check_eq("ex_pc", 64'(ex_pc), 64'(m_slot.pc));
            check_eq("ex_rs1v", 64'(ex_rs1v), 64'(m_slot.rs1v));
            check_eq("ex_rs2v", 64'(ex_rs2v), 64'(m_slot.rs2v));
            check_eq("ex_imm", 64'(ex_imm), 64'(m_slot.imm));
            check_eq("ex_rd", 64'(ex_rd), 64'(m_slot.rd));
            check_eq("ex_rd_we", 64'(ex_rd_we), 64'(m_slot.we));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w       = $urandom;
        w[11:7] = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 13);
        case (k)
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            11: w[1:0] = 2'($urandom_range(0, 2));
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        reset = 1; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0;
        wb_valid = 0; wb_rd = 0; ex_ready = 0; rs1_data = 0; rs2_data = 0;
        m_busy = '0;
        m_slot = '{valid: 0, op: 0, f3: 0, f7b5: 0, pc: 0, rs1v: 0, rs2v: 0, imm: 0,
                   rd: 0, we: 0};
        @(posedge clk);
        #1;

        // Reset, then ADDI x5,x0,7.
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        step(1, 0, 1, 32'h00700293, 32'h100, 0, 0, 1);
        step(0, 0, 1, 32'h00700293, 32'h100, 0, 0, 1);
        check_eq("addi_op", 64'(ex_op), 64'(OpOpimm));
        check_eq("addi_imm", 64'(ex_imm), 64'd7);
        check_eq("addi_rd", 64'(ex_rd), 64'd5);

        // ADD x6,x5,x5 stalls until the cycle after x5 retires.
        step(0, 0, 1, 32'h00528333, 32'h104, 0, 0, 1);
        check_eq("raw_stall", 64'(ex_valid), 64'd0);
        step(0, 0, 1, 32'h00528333, 32'h104, 0, 0, 1);
        step(0, 0, 1, 32'h00528333, 32'h104, 1, 5'd5, 1);
        step(0, 0, 1, 32'h00528333, 32'h104, 0, 0, 0);
        check_eq("add_issued", 64'(ex_valid), 64'd1);

        // Back-pressure, then LUI x7,0x12345 replaces the slot with no bubble.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h123453B7, 32'h108, 0, 0, 0);
        step(0, 0, 1, 32'h123453B7, 32'h108, 0, 0, 1);
        check_eq("lui_imm", 64'(ex_imm), 64'h12345000);

        // BEQ -4, SW -1.
        step(0, 0, 1, 32'hFE000EE3, 32'h10C, 0, 0, 1);
        check_eq("beq_imm", 64'(ex_imm), 64'hFFFFFFFC);
        step(0, 0, 1, 32'hFE002FA3, 32'h110, 0, 0, 1);
        check_eq("sw_imm", 64'(ex_imm), 64'hFFFFFFFF);

        // Flush drops the slot's claim on x9.
        step(0, 0, 1, 32'h00100493, 32'h114, 0, 0, 1);
        step(0, 1, 1, 32'h00948533, 32'h118, 0, 0, 0);
        step(0, 0, 1, 32'h00948533, 32'h118, 0, 0, 1);
        check_eq("post_flush_issue", 64'(ex_valid), 64'd1);

        // Illegal word, write to x0, writeback to x0.
        step(0, 0, 1, 32'h00000000, 32'h11C, 0, 0, 1);
        check_eq("illegal_op", 64'(ex_op), 64'(OpIllegal));
        step(0, 0, 1, 32'h00100013, 32'h120, 1, 5'd0, 1);
        step(0, 0, 1, 32'h00000013, 32'h124, 1, 5'd0, 1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 9) < 8), rand_instr(), $urandom,
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
